rst_seq_ctrl: RTL and testbench

- Parametrised reset sequencer that generalises the single "PLL lock drives CPU hwRstn" hookup.
- Qualifies N_LOCK asynchronous lock inputs: 2-flop sync, then a stability window.
- Releases N_CH active-low domain resets in a fixed staggered order (ch0 first: CPU/bus, then peripherals).
- Re-asserts all resets on lock loss, software request, or optional CPU LOCKUP. Sits in the top level between the PLL(s) and the EMPU/peripheral resets.

---
 rtl/rst_seq_ctrl_if.sv | 25 ++
 rtl/rst_seq_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Lock/reset-request inputs and sequenced reset outputs of rst_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding top level.
interface rst_seq_ctrl_if #(
   parameter int N_LOCK = 1,
   parameter int N_CH   = 3,
   parameter int CNT_W  = 8
);
   logic [N_LOCK-1:0] lock_i;
   logic              sw_rst_i;
   logic              lockup_i;
   logic [N_CH-1:0]   rstn_o;
   logic              done_o;
   logic [1:0]        state_o;
   logic [CNT_W-1:0]  fault_cnt_o;

   modport master (
      output lock_i, sw_rst_i, lockup_i,
      input  rstn_o, done_o, state_o, fault_cnt_o
   );

   modport slave (
      input  lock_i, sw_rst_i, lockup_i,
      output rstn_o, done_o, state_o, fault_cnt_o
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: qualifies synchronised PLL lock flags, then releases N_CH
// active-low domain resets in staggered order; re-asserts on lock loss or request.
module rst_seq_ctrl #(
   parameter int N_LOCK          = 1,
   parameter int N_CH            = 3,
   parameter int LOCK_STABLE_CYC = 16,
   parameter int STEP_CYC        = 4,
   parameter int HOLD_CYC        = 8,
   parameter bit LOCKUP_RST_EN   = 1'b1,
   parameter int CNT_W           = 8
) (
   input logic           HCLK_i,
   input logic           hwRst_i,
   rst_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK = 2'd0,
      ST_RELEASE   = 2'd1,
      ST_RUN       = 2'd2,
      ST_HOLD      = 2'd3
   } state_t;

   localparam int STAB_W = (LOCK_STABLE_CYC > 1) ? $clog2(LOCK_STABLE_CYC) : 1;
   localparam int STEP_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
   localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
   localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);

   state_t             r_state;
   state_t             w_next_state;
   logic [N_LOCK-1:0]  r_sync1;
   logic [N_LOCK-1:0]  r_sync2;
   logic [STAB_W-1:0]  r_stab_cnt;
   logic [STEP_W-1:0]  r_step_cnt;
   logic [HOLD_W-1:0]  r_hold_cnt;
   logic [IDX_W-1:0]   r_idx;
   logic [N_CH-1:0]    r_rstn;
   logic               r_done;
   logic [CNT_W-1:0]   r_fault;

   logic w_lock_all_s;
   logic w_loss;
   logic w_soft;
   logic w_stab_done;
   logic w_step_done;
   logic w_last_ch;
   logic w_hold_done;

   assign w_lock_all_s = &r_sync2;
   // Lock low is only a fault once release has begun; priority is loss > soft.
   assign w_loss       = !w_lock_all_s && ((r_state == ST_RELEASE) || (r_state == ST_RUN));
   assign w_soft       = bus.sw_rst_i ||
                         (LOCKUP_RST_EN && bus.lockup_i && (r_state == ST_RUN));
   assign w_stab_done  = w_lock_all_s && (r_stab_cnt == STAB_LAST);
   assign w_step_done  = (r_step_cnt == STEP_LAST);
   assign w_last_ch    = (r_idx == IDX_LAST);
   assign w_hold_done  = (r_hold_cnt == HOLD_LAST);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge HCLK_i or posedge hwRst_i) begin
      if (hwRst_i) r_state <= ST_WAIT_LOCK;
      else         r_state <= w_next_state;
   end

   // NOTE: defaulting the next state before any branch keeps this block latch-free.
   always_comb begin
      w_next_state = r_state;
      if (w_loss) begin
         w_next_state = ST_WAIT_LOCK;
      end else if (w_soft) begin
         w_next_state = ST_HOLD;
      end else begin
         case (r_state)
            ST_WAIT_LOCK: if (w_stab_done) w_next_state = (N_CH == 1) ? ST_RUN : ST_RELEASE;
            ST_RELEASE:   if (w_step_done && w_last_ch) w_next_state = ST_RUN;
            ST_HOLD:      if (w_hold_done) w_next_state = ST_WAIT_LOCK;
            default:      ;
         endcase
      end
   end

   always_comb begin
      bus.rstn_o      = r_rstn;
      bus.done_o      = r_done;
      bus.state_o     = r_state;
      bus.fault_cnt_o = r_fault;
   end

   always_ff @(posedge HCLK_i or posedge hwRst_i) begin
      if (hwRst_i) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= bus.lock_i;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge HCLK_i or posedge hwRst_i) begin
      if (hwRst_i) begin
         r_stab_cnt <= '0;
         r_step_cnt <= '0;
         r_hold_cnt <= '0;
         r_idx      <= '0;
         r_rstn     <= '0;
         r_done     <= 1'b0;
         r_fault    <= '0;
      end else if (w_loss) begin
         r_rstn     <= '0;
         r_done     <= 1'b0;
         r_stab_cnt <= '0;
         r_step_cnt <= '0;
         r_idx      <= '0;
         if (r_fault != '1) r_fault <= r_fault + 1'b1;
      end else if (w_soft) begin
         r_rstn     <= '0;
         r_done     <= 1'b0;
         r_stab_cnt <= '0;
         r_step_cnt <= '0;
         r_idx      <= '0;
         r_hold_cnt <= '0;
      end else begin
         case (r_state)
            ST_WAIT_LOCK: begin
               if (!w_lock_all_s) begin
                  r_stab_cnt <= '0;
               end else if (w_stab_done) begin
                  r_stab_cnt <= '0;
                  r_rstn[0]  <= 1'b1;
                  r_idx      <= IDX_W'(1);
                  r_step_cnt <= '0;
                  r_done     <= (N_CH == 1) ? 1'b1 : 1'b0;
               end else begin
                  r_stab_cnt <= r_stab_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               if (w_step_done) begin
                  r_step_cnt <= '0;
                  r_idx      <= r_idx + 1'b1;
                  for (int k = 1; k < N_CH; k++) begin
                     if (r_idx == IDX_W'(k)) r_rstn[k] <= 1'b1;
                  end
                  if (w_last_ch) r_done <= 1'b1;
               end else begin
                  r_step_cnt <= r_step_cnt + 1'b1;
               end
            end
            ST_HOLD: r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: every output change is predicted into a
// per-instance queue when stimulus is driven and matched when it appears.
module tb_rst_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_main;
   logic rst_nolk;
   logic rst_small;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   rst_seq_ctrl_if #(.N_LOCK(1), .N_CH(3), .CNT_W(8)) m_if ();
   rst_seq_ctrl_if #(.N_LOCK(1), .N_CH(3), .CNT_W(8)) n_if ();
   rst_seq_ctrl_if #(.N_LOCK(2), .N_CH(1), .CNT_W(8)) s_if ();

   rst_seq_ctrl u_main (
      .HCLK_i  (clk),
      .hwRst_i (rst_main),
      .bus     (m_if.slave)
   );

   rst_seq_ctrl #(.LOCKUP_RST_EN(1'b0)) u_nolk (
      .HCLK_i  (clk),
      .hwRst_i (rst_nolk),
      .bus     (n_if.slave)
   );

   rst_seq_ctrl #(.N_LOCK(2), .N_CH(1), .STEP_CYC(1)) u_small (
      .HCLK_i  (clk),
      .hwRst_i (rst_small),
      .bus     (s_if.slave)
   );

   typedef struct packed {
      int          cyc;
      logic [13:0] val;
   } exp_t;

   exp_t q_main[$];
   exp_t q_nolk[$];
   exp_t q_small[$];

   logic [13:0] val_main, val_nolk, val_small;
   logic [13:0] last_main, last_nolk, last_small;

   assign val_main  = {m_if.rstn_o, m_if.done_o, m_if.state_o, m_if.fault_cnt_o};
   assign val_nolk  = {n_if.rstn_o, n_if.done_o, n_if.state_o, n_if.fault_cnt_o};
   assign val_small = {2'b00, s_if.rstn_o, s_if.done_o, s_if.state_o, s_if.fault_cnt_o};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic push(input int which, input int c, input logic [2:0] r, input logic d,
                       input logic [1:0] s, input logic [7:0] f);
      exp_t e;
      e.cyc = c;
      e.val = {r, d, s, f};
      case (which)
         0:       q_main.push_back(e);
         1:       q_nolk.push_back(e);
         default: q_small.push_back(e);
      endcase
   endtask

   // Three-channel release: ch0 at t0, ch1 four edges later, ch2 + done four more.
   task automatic push_release(input int which, input int t0, input logic [7:0] f);
      push(which, t0,     3'b001, 1'b0, 2'd1, f);
      push(which, t0 + 4, 3'b011, 1'b0, 2'd1, f);
      push(which, t0 + 8, 3'b111, 1'b1, 2'd2, f);
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((q_main.size() + q_nolk.size() + q_small.size()) != 0 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("drain", 32'(q_main.size() + q_nolk.size() + q_small.size()), 32'd0);
   endtask

   always @(negedge clk) begin : mon_main
      exp_t e;
      if (!mon_en) begin
         last_main <= val_main;
      end else if (val_main !== last_main) begin
         if (q_main.size() == 0) begin
            check("main_unexpected", 32'(val_main), 32'(last_main));
         end else begin
            e = q_main.pop_front();
            check("main_cyc", 32'(cyc), 32'(e.cyc));
            check("main_val", 32'(val_main), 32'(e.val));
         end
         last_main <= val_main;
      end
   end

   always @(negedge clk) begin : mon_nolk
      exp_t e;
      if (!mon_en) begin
         last_nolk <= val_nolk;
      end else if (val_nolk !== last_nolk) begin
         if (q_nolk.size() == 0) begin
            check("nolk_unexpected", 32'(val_nolk), 32'(last_nolk));
         end else begin
            e = q_nolk.pop_front();
            check("nolk_cyc", 32'(cyc), 32'(e.cyc));
            check("nolk_val", 32'(val_nolk), 32'(e.val));
         end
         last_nolk <= val_nolk;
      end
   end

   always @(negedge clk) begin : mon_small
      exp_t e;
      if (!mon_en) begin
         last_small <= val_small;
      end else if (val_small !== last_small) begin
         if (q_small.size() == 0) begin
            check("small_unexpected", 32'(val_small), 32'(last_small));
         end else begin
            e = q_small.pop_front();
            check("small_cyc", 32'(cyc), 32'(e.cyc));
            check("small_val", 32'(val_small), 32'(e.val));
         end
         last_small <= val_small;
      end
   end

   initial begin
      int c;
      int g;
      logic [7:0] f;

      rst_main  = 1'b1;
      rst_nolk  = 1'b1;
      rst_small = 1'b1;
      m_if.lock_i = 1'b0;  m_if.sw_rst_i = 1'b0;  m_if.lockup_i = 1'b0;
      n_if.lock_i = 1'b0;  n_if.sw_rst_i = 1'b0;  n_if.lockup_i = 1'b0;
      s_if.lock_i = 2'b00; s_if.sw_rst_i = 1'b0;  s_if.lockup_i = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_rstn",  32'(m_if.rstn_o), 32'd0);
      check("rst_done",  32'(m_if.done_o), 32'd0);
      check("rst_state", 32'(m_if.state_o), 32'd0);
      check("rst_fault", 32'(m_if.fault_cnt_o), 32'd0);
      check("rst_nolk_state", 32'(n_if.state_o), 32'd0);
      check("rst_small_rstn", 32'(s_if.rstn_o), 32'd0);

      rst_main  = 1'b0;
      rst_nolk  = 1'b0;
      rst_small = 1'b0;
      mon_en    = 1'b1;
      @(negedge clk);

      // Clean lock rise: ch0 at E0+17, ch1 +21, ch2/done +25 (E0 = next edge).
      c = cyc;
      m_if.lock_i = 1'b1;
      n_if.lock_i = 1'b1;
      push_release(0, c + 18, 8'd0);
      push_release(1, c + 18, 8'd0);
      drain(60);

      // Lock loss in RUN is seen three edges after the drop.
      c = cyc;
      m_if.lock_i = 1'b0;
      push(0, c + 3, 3'b000, 1'b0, 2'd0, 8'd1);
      drain(20);

      // One-cycle glitch when stab_cnt==10 restarts the window.
      c = cyc;
      m_if.lock_i = 1'b1;
      repeat (12) @(negedge clk);
      check("glitch_still_wait", 32'(m_if.state_o), 32'd0);
      m_if.lock_i = 1'b0;
      g = cyc + 1;
      @(negedge clk);
      m_if.lock_i = 1'b1;
      push(0, g + 18, 3'b001, 1'b0, 2'd1, 8'd1);
      push(0, g + 22, 3'b011, 1'b0, 2'd1, 8'd1);
      drain(60);

      // sw_rst just after ch1 release, then again inside HOLD to restart it.
      c = cyc;
      push(0, c + 1,  3'b000, 1'b0, 2'd3, 8'd1);
      push(0, c + 13, 3'b000, 1'b0, 2'd0, 8'd1);
      push_release(0, c + 29, 8'd1);
      m_if.sw_rst_i = 1'b1;
      @(negedge clk);
      m_if.sw_rst_i = 1'b0;
      repeat (3) @(negedge clk);
      m_if.sw_rst_i = 1'b1;
      @(negedge clk);
      m_if.sw_rst_i = 1'b0;
      drain(80);

      // lockup in RUN enters HOLD; a lockup pulse inside HOLD is ignored.
      c = cyc;
      push(0, c + 1, 3'b000, 1'b0, 2'd3, 8'd1);
      push(0, c + 9, 3'b000, 1'b0, 2'd0, 8'd1);
      push_release(0, c + 25, 8'd1);
      m_if.lockup_i = 1'b1;
      n_if.lockup_i = 1'b1;
      @(negedge clk);
      m_if.lockup_i = 1'b0;
      n_if.lockup_i = 1'b0;
      repeat (2) @(negedge clk);
      m_if.lockup_i = 1'b1;
      @(negedge clk);
      m_if.lockup_i = 1'b0;
      drain(80);
      check("nolk_state_run", 32'(n_if.state_o), 32'd2);
      check("nolk_done", 32'(n_if.done_o), 32'd1);

      // Lock loss and sw_rst on the same edge: loss wins.
      c = cyc;
      m_if.lock_i = 1'b0;
      push(0, c + 3, 3'b000, 1'b0, 2'd0, 8'd2);
      repeat (2) @(negedge clk);
      m_if.sw_rst_i = 1'b1;
      @(negedge clk);
      m_if.sw_rst_i = 1'b0;
      drain(20);

      // 300 further losses saturate the 8-bit fault counter.
      f = 8'd2;
      for (int i = 0; i < 300; i++) begin
         c = cyc;
         m_if.lock_i = 1'b1;
         push(0, c + 18, 3'b001, 1'b0, 2'd1, f);
         drain(40);
         c = cyc;
         m_if.lock_i = 1'b0;
         f = (f == 8'hFF) ? f : f + 8'd1;
         push(0, c + 3, 3'b000, 1'b0, 2'd0, f);
         drain(20);
      end
      check("fault_sat", 32'(m_if.fault_cnt_o), 32'd255);

      // hwRst mid-RELEASE returns everything to reset values without a clock edge.
      c = cyc;
      m_if.lock_i = 1'b1;
      push(0, c + 18, 3'b001, 1'b0, 2'd1, 8'hFF);
      drain(40);
      push(0, cyc + 1, 3'b000, 1'b0, 2'd0, 8'd0);
      rst_main = 1'b1;
      #1;
      check("hw_rstn",  32'(m_if.rstn_o), 32'd0);
      check("hw_done",  32'(m_if.done_o), 32'd0);
      check("hw_state", 32'(m_if.state_o), 32'd0);
      check("hw_fault", 32'(m_if.fault_cnt_o), 32'd0);
      m_if.lock_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_main = 1'b0;
      drain(5);

      // Two locks, one channel: only one lock high never releases.
      s_if.lock_i = 2'b01;
      repeat (30) @(negedge clk);
      check("small_one_lock_state", 32'(s_if.state_o), 32'd0);
      check("small_one_lock_rstn", 32'(s_if.rstn_o), 32'd0);

      // Both high, lock[1] dips for one cycle mid-window, then full window.
      c = cyc;
      s_if.lock_i = 2'b11;
      repeat (8) @(negedge clk);
      s_if.lock_i = 2'b01;
      g = cyc + 1;
      @(negedge clk);
      s_if.lock_i = 2'b11;
      push(2, g + 18, 3'b001, 1'b1, 2'd2, 8'd0);
      drain(60);

      c = cyc;
      s_if.lock_i = 2'b10;
      push(2, c + 3, 3'b000, 1'b0, 2'd0, 8'd1);
      drain(20);

      repeat (10) @(negedge clk);
      drain(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
